// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, types and helpers for the register file
package regfile_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_AW    = $clog2(DEF_NREGS);

    // Widest busy vector the popcount helper accepts; narrower vectors are zero-extended.
    localparam int MAX_POP_W = 256;

    typedef logic [DEF_AW-1:0]   reg_addr_t;
    typedef logic [DEF_XLEN-1:0] xword_t;

    function automatic int popcount(input logic [MAX_POP_W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAX_POP_W; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits with incremental population count
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = DEF_NREGS,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS),
    localparam int CW      = $clog2(NREGS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy_vec,
    output logic [CW-1:0]    busy_cnt
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             set_ok;
    logic             inc;
    logic             dec;

    // Next busy state: flush beats everything, then issue-set beats writeback-clear.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        set_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));
        inc    = 1'b0;
        dec    = 1'b0;
        if (flush) begin
            busy_d = '0;
            cnt_d  = '0;
        end else begin
            // A clear only counts if the register was busy and no same-target issue re-sets it.
            inc = set_ok && !busy_q[iss_addr];
            dec = wr_en && busy_q[wr_addr] && !(set_ok && (iss_addr == wr_addr));
            if (wr_en) begin
                busy_d[wr_addr] = 1'b0;
            end
            if (set_ok) begin
                busy_d[iss_addr] = 1'b1;
            end
            case ({inc, dec})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Busy state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Incremental counter must always match the population of the busy vector.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (cnt_q == CW'(popcount(MAX_POP_W'(busy_q))));
        end
    end

    assign busy_vec = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with write-through bypass and busy scoreboard
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS),
    localparam int CW      = $clog2(NREGS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              flush,
    output logic [NREGS-1:0]  busy_vec,
    output logic [CW-1:0]     busy_cnt
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic            wr_commit;

    assign wr_commit = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

    // Data array: one synchronous write port, hardwired zero register never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (wr_commit) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_vec (busy_vec),
        .busy_cnt (busy_cnt)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            is_zero;
        logic            wr_hit;
        logic [XLEN-1:0] data;

        assign addr    = rd_addr[i*AW +: AW];
        assign is_zero = (ZERO_REG != 0) && (addr == '0);
        assign wr_hit  = wr_en && (wr_addr == addr);

        // Read mux: zero register first, then same-cycle writeback bypass, then the array.
        always_comb begin
            data = regs_q[addr];
            if (is_zero) begin
                data = '0;
            end else if (wr_hit) begin
                data = wr_data;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = data;
        // A writeback landing this cycle satisfies the hazard, so it hides the busy flag.
        assign rd_busy[i] = busy_vec[addr] && !wr_hit && !is_zero;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised integer register file with a per-register busy scoreboard for the pipelined core. It provides NRD combinational read ports with write-through bypass and one synchronous write port. It also tracks which registers have an in-flight producer. Issue marks a destination busy, writeback clears it, and flush clears all busy bits. Decode uses rd_busy to stall on RAW hazards.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >= 2)
NRD, 2, number of read ports (>= 1)
ZERO_REG, 1, if 1 then register 0 reads as zero, ignores writes, and is never marked busy
AW (localparam), $clog2(NREGS), register address width
CW (localparam), $clog2(NREGS+1), busy counter width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rd_addr  input  NRD*AW  packed read addresses, port i at [i*AW +: AW]
rd_data  output  NRD*XLEN  packed read data, port i at [i*XLEN +: XLEN]
rd_busy  output  NRD  busy flag per read port
wr_en  input  1  writeback strobe
wr_addr  input  AW  writeback destination
wr_data  input  XLEN  writeback data
iss_en  input  1  issue strobe, marks iss_addr busy
iss_addr  input  AW  issued instruction's destination
flush  input  1  clear all busy bits (pipeline squash)
busy_vec  output  NREGS  registered busy bit per register
busy_cnt  output  CW  registered count of set busy bits

Behaviour:
- Reset (rst_n low, asynchronous): all registers become 0, busy_vec becomes 0, busy_cnt becomes 0. Outputs reflect this immediately, with no clock needed. Deassertion is sampled by the next clk edge.
- Write: on posedge clk with wr_en=1, regs[wr_addr] <= wr_data. When ZERO_REG=1 and wr_addr=0, nothing is written.
- Read (combinational, 0 latency):
  - rd_data[i] = 0 if ZERO_REG and rd_addr[i]=0.
  - Otherwise, if wr_en and wr_addr==rd_addr[i], rd_data[i] = wr_data (write-through bypass).
  - Otherwise, rd_data[i] = regs[rd_addr[i]].
- rd_busy[i] = busy_vec[rd_addr[i]] & ~(wr_en & wr_addr==rd_addr[i]). A same-cycle writeback hides the busy flag. rd_busy is always 0 for address 0 when ZERO_REG=1.
- Busy update (posedge clk), next state per register r:
  - flush=1: busy[r] <= 0 for all r. flush overrides iss_en. wr_en still commits data.
  - Otherwise, set if iss_en & iss_addr==r; clear if wr_en & wr_addr==r.
  - Issue and writeback to the same r in the same cycle: set wins (a new producer supersedes the old one), and the data still commits.
  - iss_en to register 0 with ZERO_REG=1 is ignored.
  - Issue to an already-busy register keeps it busy. Writeback to a non-busy register writes data only.
- busy_cnt: registered. Always equals popcount(busy_vec) after every edge. It is updated incrementally:
  - +1 when a not-busy register is set.
  - -1 when a busy register is cleared.
  - Both, or neither, leaves it unchanged.
  - Flush loads 0.
  - The counter never wraps, because the range is 0..NREGS.
- Reset mid-operation: pending strobes in the same cycle are discarded, and all state returns to reset values.
- No X propagation: out-of-range addresses cannot occur because NREGS is a power of two.

Decomposition:
- Package regfile_pkg holds:
  - default XLEN and NREGS constants
  - typedef reg_addr_t (logic [AW-1:0])
  - typedef xword_t (logic [XLEN-1:0])
  - function popcount for assertions
- Sub-module rf_scoreboard holds busy_vec, busy_cnt and the set/clear/flush priority logic.
- The top level keeps the data array, bypass muxes and port unpacking.

Test Plan:
- Reset then read: rst_n=0 mid-run, then release. All ports read 0, busy_vec=0, busy_cnt=0 with no clock edge required during reset.
- Write/read: wr x5=0xDEADBEEF, next cycle rd_addr0=5 -> 0xDEADBEEF. Same cycle as the write, rd_addr1=5 -> bypass gives 0xDEADBEEF. wr x0=0x1234 -> x0 still reads 0.
- Scoreboard: iss x7 -> busy_vec[7]=1, busy_cnt=1, rd_busy=1 on x7. Next cycle wr x7=0x42 -> in that cycle rd_busy=0 and rd_data=0x42. After the edge busy_vec[7]=0 and busy_cnt=0.
- Collision: x3 busy, then iss x3 and wr x3=0x99 in the same cycle -> x3 still busy, busy_cnt unchanged at 1, x3 reads 0x99.
- Flush: iss x1, x2, x9 on consecutive cycles (busy_cnt=3). Then flush together with iss x4 -> busy_vec=0, busy_cnt=0.
- Parameter sweep: NRD=3, NREGS=16, XLEN=64, ZERO_REG=0. wr x0=0xFFFF_FFFF_FFFF_FFFF reads back on all 3 ports. iss x0 sets busy_vec[0].
